// File: rtl/evenodd_pkg.sv
// Shared types and constants for the even/odd counter arbiter slice.
// Imported by the arbiter top and its round-robin picker.
package evenodd_pkg;

   localparam int LEN_W_DEF = 4;
   localparam int CNT_W_DEF = 3;

   localparam logic OWNER_EVEN = 1'b0;
   localparam logic OWNER_ODD  = 1'b1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CLR  = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   typedef enum logic [1:0] {
      IDLE = S_IDLE,
      CLR  = S_CLR,
      RUN  = S_RUN,
      DONE = S_DONE
   } state_e;

   // Mode applied to the counter's oe for a given owner (1 = odd sequence).
   function automatic logic owner_to_oe(input logic owner);
      return (owner == OWNER_ODD) ? 1'b1 : 1'b0;
   endfunction

endpackage

// File: rtl/evenodd_arbiter_if.sv
// Requester, counter and result-stream signals of the even/odd arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface evenodd_arbiter_if #(
   parameter int LEN_W = 4,
   parameter int CNT_W = 3
) ();

   logic             req_even;
   logic [LEN_W-1:0] len_even;
   logic             req_odd;
   logic [LEN_W-1:0] len_odd;
   logic             gnt_even;
   logic             gnt_odd;
   logic             cnt_rst;
   logic             cnt_oe;
   logic [CNT_W-1:0] cnt_val;
   logic             val_out;
   logic [CNT_W-1:0] data_out;
   logic             owner;
   logic             busy;
   logic             done;

   modport slave (
      input  req_even, len_even, req_odd, len_odd, cnt_val,
      output gnt_even, gnt_odd, cnt_rst, cnt_oe,
             val_out, data_out, owner, busy, done
   );

   modport master (
      output req_even, len_even, req_odd, len_odd, cnt_val,
      input  gnt_even, gnt_odd, cnt_rst, cnt_oe,
             val_out, data_out, owner, busy, done
   );

endinterface

// File: rtl/evenodd_arbiter_rr_arb2.sv
// Two-way round-robin picker: on a tie the requester that did not win last time wins.
// Purely combinational; the last-owner pointer is kept by the caller.
module rr_arb2
   import evenodd_pkg::*;
(
   input  logic [1:0] req_i,   // bit 0 = even, bit 1 = odd
   input  logic       last_i,  // owner of the most recently completed burst
   output logic [1:0] gnt_o,
   output logic       win_o
);

   // Winner selection and one-hot grant.
   always_comb begin
      win_o = OWNER_EVEN;
      gnt_o = 2'b00;
      case (req_i)
         2'b01: begin
            win_o = OWNER_EVEN;
            gnt_o = 2'b01;
         end
         2'b10: begin
            win_o = OWNER_ODD;
            gnt_o = 2'b10;
         end
         2'b11: begin
            win_o = ~last_i;
            gnt_o = (last_i == OWNER_ODD) ? 2'b01 : 2'b10;
         end
         default: begin
            win_o = OWNER_EVEN;
            gnt_o = 2'b00;
         end
      endcase
   end

endmodule

// File: rtl/evenodd_arbiter.sv
// Round-robin sequencer in front of the even/odd counter: grants one requester,
// clears the counter, runs it for the latched length and streams its values back.
module evenodd_arbiter
   import evenodd_pkg::*;
#(
   parameter int LEN_W = LEN_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   evenodd_arbiter_if.slave  bus
);

   localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

   state_e           state_q, state_d;
   logic             owner_q, owner_d;
   logic             last_q, last_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] step_q, step_d;

   logic [1:0]       arb_req_s;
   logic [1:0]       arb_gnt_s;
   logic             arb_win_s;
   logic             last_step_s;

   logic             gnt_even_s;
   logic             gnt_odd_s;
   logic             cnt_rst_s;
   logic             cnt_oe_s;
   logic             val_out_s;
   logic [CNT_W-1:0] data_out_s;
   logic             owner_s;
   logic             busy_s;
   logic             done_s;

   assign arb_req_s   = {bus.req_odd, bus.req_even};
   assign last_step_s = (step_q == (len_q - LEN_ONE));

   rr_arb2 u_rr_arb2 (
      .req_i  (arb_req_s),
      .last_i (last_q),
      .gnt_o  (arb_gnt_s),
      .win_o  (arb_win_s)
   );

   // State, burst bookkeeping and round-robin pointer registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         owner_q <= OWNER_EVEN;
         last_q  <= OWNER_ODD;   // even takes the first tie
         len_q   <= '0;
         step_q  <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         len_q   <= len_d;
         step_q  <= step_d;
      end
   end

   // Next-state logic; requests and lengths are only looked at in IDLE.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      len_d   = len_q;
      step_d  = step_q;
      case (state_q)
         IDLE: begin
            if (arb_gnt_s != 2'b00) begin
               owner_d = arb_win_s;
               len_d   = arb_gnt_s[1] ? bus.len_odd : bus.len_even;
               state_d = CLR;
            end else begin
               state_d = IDLE;
            end
         end
         CLR: begin
            step_d = '0;
            if (len_q != '0) begin
               state_d = RUN;
            end else begin
               state_d = DONE;
            end
         end
         RUN: begin
            step_d = step_q + LEN_ONE;
            if (last_step_s) begin
               state_d = DONE;
            end else begin
               state_d = RUN;
            end
         end
         DONE: begin
            last_d  = owner_q;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output decode from the state register; data is a zero-latency pass-through.
   always_comb begin
      gnt_even_s = 1'b0;
      gnt_odd_s  = 1'b0;
      cnt_rst_s  = 1'b0;
      cnt_oe_s   = 1'b0;
      val_out_s  = 1'b0;
      data_out_s = '0;
      owner_s    = OWNER_EVEN;
      busy_s     = 1'b0;
      done_s     = 1'b0;
      case (state_q)
         IDLE: begin
            busy_s = 1'b0;
         end
         CLR: begin
            busy_s    = 1'b1;
            cnt_rst_s = 1'b1;
         end
         RUN: begin
            busy_s     = 1'b1;
            val_out_s  = 1'b1;
            data_out_s = bus.cnt_val;
         end
         DONE: begin
            busy_s = 1'b1;
            done_s = 1'b1;
         end
         default: begin
            busy_s = 1'b0;
         end
      endcase
      if (busy_s) begin
         gnt_even_s = (owner_q == OWNER_EVEN);
         gnt_odd_s  = (owner_q == OWNER_ODD);
         cnt_oe_s   = owner_to_oe(owner_q);
         owner_s    = owner_q;
      end else begin
         gnt_even_s = 1'b0;
         gnt_odd_s  = 1'b0;
      end
   end

   assign bus.gnt_even = gnt_even_s;
   assign bus.gnt_odd  = gnt_odd_s;
   assign bus.cnt_rst  = cnt_rst_s;
   assign bus.cnt_oe   = cnt_oe_s;
   assign bus.val_out  = val_out_s;
   assign bus.data_out = data_out_s;
   assign bus.owner    = owner_s;
   assign bus.busy     = busy_s;
   assign bus.done     = done_s;

endmodule

// File: tb/tb_evenodd_arbiter.sv
// Bench for evenodd_arbiter: a behavioural even/odd counter plus a queue-based
// model of the expected per-cycle outputs, directed scenarios and random traffic.
module tb_evenodd_arbiter;

   localparam int LW = 4;
   localparam int CW = 3;

   typedef logic [10:0] vec_t;
   typedef logic [2:0]  d3_q_t[$];

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   evenodd_arbiter_if #(.LEN_W(LW), .CNT_W(CW)) bus ();

   evenodd_arbiter #(.LEN_W(LW), .CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   // The external even/odd counter: rst clears, oe=1 walks 0,1,3,5,7,0, oe=0 steps by 2.
   logic [CW-1:0] cnt_r = 3'd0;
   always @(posedge clk) begin
      if (bus.cnt_rst === 1'b1)
         cnt_r <= 3'd0;
      else if (bus.cnt_oe === 1'b1)
         cnt_r <= (cnt_r == 3'd0) ? 3'd1 : ((cnt_r == 3'd7) ? 3'd0 : cnt_r + 3'd2);
      else
         cnt_r <= cnt_r + 3'd2;
   end
   assign bus.cnt_val = cnt_r;

   // k-th value of a burst, straight from the sequence definitions.
   function automatic logic [2:0] seq_val(input logic odd, input int k);
      int i;
      if (odd) begin
         i = k % 5;
         return (i == 0) ? 3'd0 : 3'(2 * i - 1);
      end
      return 3'(2 * (k % 4));
   endfunction

   function automatic vec_t mk(input logic o, input logic cr, input logic v,
                               input logic [2:0] d, input logic dn);
      return {~o, o, cr, o, v, d, o, 1'b1, dn};
   endfunction

   function automatic longint pack3(input d3_q_t q);
      longint p = 0;
      foreach (q[i]) p = (p << 3) | longint'(q[i]);
      return p;
   endfunction

   // Model: a queue of expected output vectors for the burst in flight; empty means idle.
   vec_t exp_q[$];
   logic last_m = 1'b1;
   logic mvalid = 1'b0;
   vec_t popped;
   logic win_m;
   int   len_m;
   always @(posedge clk) begin
      if (rst) begin
         exp_q.delete();
         last_m <= 1'b1;
         mvalid <= 1'b1;
      end else if (mvalid) begin
         if (exp_q.size() > 0) begin
            popped = exp_q.pop_front();
            if (popped[0]) last_m <= popped[2];
         end else if (bus.req_even || bus.req_odd) begin
            win_m = (bus.req_even && bus.req_odd) ? ~last_m : bus.req_odd;
            len_m = win_m ? int'(bus.len_odd) : int'(bus.len_even);
            exp_q.push_back(mk(win_m, 1'b1, 1'b0, 3'd0, 1'b0));
            for (int k = 0; k < len_m; k++)
               exp_q.push_back(mk(win_m, 1'b0, 1'b1, seq_val(win_m, k), 1'b0));
            exp_q.push_back(mk(win_m, 1'b0, 1'b0, 3'd0, 1'b1));
         end
      end
   end

   // Observed stream records for the directed literal checks.
   d3_q_t cap;
   d3_q_t gq;
   int busy_cnt = 0;
   int done_cnt = 0;

   // Per-cycle comparison against the model, sampled mid-cycle.
   vec_t act_v;
   vec_t exp_v;
   always @(negedge clk) begin
      if (mvalid) begin
         act_v = {bus.gnt_even, bus.gnt_odd, bus.cnt_rst, bus.cnt_oe, bus.val_out,
                  bus.data_out, bus.owner, bus.busy, bus.done};
         exp_v = (exp_q.size() > 0) ? exp_q[0] : 11'd0;
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL cycle_outputs t=%0t actual=%b required=%b (ge go cr oe v ddd ow b dn)",
                     $time, act_v, exp_v);
         end
         checks++;
         if (bus.gnt_even === 1'b1 && bus.gnt_odd === 1'b1) begin
            errors++;
            $display("FAIL gnt_exclusive t=%0t actual=11 required=not both high", $time);
         end
         if (bus.val_out === 1'b1) cap.push_back(bus.data_out);
         if (bus.cnt_rst === 1'b1) gq.push_back({2'b00, bus.gnt_odd});
         if (bus.busy === 1'b1) busy_cnt++;
         if (bus.done === 1'b1) done_cnt++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, req);
      end
   endtask

   task automatic clear_obs();
      cap.delete();
      gq.delete();
      busy_cnt = 0;
      done_cnt = 0;
   endtask

   task automatic wait_done(input string nm, input int bound, output int n);
      n = 0;
      while (bus.done !== 1'b1 && n < bound) begin
         tick();
         n++;
      end
      checks++;
      if (bus.done !== 1'b1) begin
         errors++;
         $display("FAIL %s_timeout actual=no done required=done within %0d cycles", nm, bound);
      end
   endtask

   task automatic run_burst(input string nm, input logic odd, input int len, output int lat);
      clear_obs();
      if (odd) begin
         bus.req_odd = 1'b1;
         bus.len_odd = LW'(len);
      end else begin
         bus.req_even = 1'b1;
         bus.len_even = LW'(len);
      end
      tick();
      bus.req_odd  = 1'b0;
      bus.req_even = 1'b0;
      wait_done(nm, 40, lat);
      tick();
   endtask

   int lat;

   initial begin
      bus.req_even = 1'b0;
      bus.req_odd  = 1'b0;
      bus.len_even = '0;
      bus.len_odd  = '0;
      rst = 1'b1;
      repeat (3) tick();
      chk("reset_busy", longint'(bus.busy), 0);
      chk("reset_gnt", longint'({bus.gnt_even, bus.gnt_odd}), 0);
      rst = 1'b0;
      tick();

      run_burst("odd5", 1'b1, 5, lat);
      chk("odd5_latency", lat, 6);
      chk("odd5_count", cap.size(), 5);
      chk("odd5_data", pack3(cap), 'o01357);
      chk("odd5_done_cnt", done_cnt, 1);

      run_burst("even5", 1'b0, 5, lat);
      chk("even5_count", cap.size(), 5);
      chk("even5_data", pack3(cap), 'o02460);

      rst = 1'b1;
      tick();
      rst = 1'b0;
      clear_obs();
      bus.req_even = 1'b1;
      bus.req_odd  = 1'b1;
      bus.len_even = 4'd2;
      bus.len_odd  = 4'd2;
      repeat (19) tick();
      bus.req_even = 1'b0;
      bus.req_odd  = 1'b0;
      repeat (3) tick();
      chk("rr_grants", pack3(gq), 'o0101);
      chk("rr_grant_count", gq.size(), 4);
      chk("rr_data", pack3(cap), 'o02010201);
      chk("rr_done_cnt", done_cnt, 4);

      run_burst("zero", 1'b1, 0, lat);
      chk("zero_busy_cycles", busy_cnt, 2);
      chk("zero_done_cnt", done_cnt, 1);
      chk("zero_val_count", cap.size(), 0);

      clear_obs();
      bus.req_odd = 1'b1;
      bus.len_odd = 4'd8;
      tick();
      bus.req_odd = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_busy", longint'(bus.busy), 0);
      chk("midrst_gnt_odd", longint'(bus.gnt_odd), 0);
      clear_obs();
      bus.req_even = 1'b1;
      bus.req_odd  = 1'b1;
      bus.len_even = 4'd1;
      bus.len_odd  = 4'd1;
      tick();
      bus.req_even = 1'b0;
      bus.req_odd  = 1'b0;
      wait_done("midrst_tie", 40, lat);
      tick();
      chk("midrst_tie_winner", pack3(gq), 0);
      chk("midrst_tie_count", gq.size(), 1);

      clear_obs();
      bus.req_odd = 1'b1;
      bus.len_odd = 4'd6;
      tick();
      tick();
      bus.req_odd = 1'b0;
      bus.len_odd = 4'd2;
      wait_done("ignore", 40, lat);
      tick();
      chk("ignore_count", cap.size(), 6);
      chk("ignore_data", pack3(cap), 'o013570);

      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 3) == 0) bus.req_even = ~bus.req_even;
         if ($urandom_range(0, 3) == 0) bus.req_odd  = ~bus.req_odd;
         if ($urandom_range(0, 2) == 0) bus.len_even = LW'($urandom_range(0, 9));
         if ($urandom_range(0, 2) == 0) bus.len_odd  = LW'($urandom_range(0, 15));
         rst = ($urandom_range(0, 79) == 0);
         tick();
      end
      rst = 1'b0;
      bus.req_even = 1'b0;
      bus.req_odd  = 1'b0;
      repeat (20) tick();
      chk("final_idle", longint'(bus.busy), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
